// File: rtl/poly_adsr_if.sv
// Channel-tagged envelope output stream of poly_adsr: one voice level per clock
// plus the per-voice activity map.
interface poly_adsr_if #(
  parameter int unsigned NCH = 8,
  parameter int unsigned OW  = 18,
  parameter int unsigned CW  = 3
);
  logic [OW-1:0]  env_out;
  logic [CW-1:0]  env_ch;
  logic           env_valid;
  logic [NCH-1:0] env_active;

  modport master (
    output env_out,
    output env_ch,
    output env_valid,
    output env_active
  );

  modport slave (
    input env_out,
    input env_ch,
    input env_valid,
    input env_active
  );
endinterface

// File: rtl/poly_adsr.sv
// Time-multiplexed ADSR envelope generator: NCH voices share one datapath, one voice per clock.
// Define POLY_ADSR_HARD_RETRIG_EN to restart every note from silence (default: soft retrigger).
module poly_adsr #(
  parameter int unsigned NCH  = 8,
  parameter int unsigned OW   = 18,
  parameter int unsigned FRAC = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NCH-1:0]   gate,
  input  logic [OW-1:0]    a_rate,
  input  logic [OW-1:0]    d_rate,
  input  logic [OW-1:0]    sus_lev,
  input  logic [OW-1:0]    r_rate,
  input  logic [OW-1:0]    pk_val,
  poly_adsr_if.master      env
);
  localparam int unsigned AW = OW + FRAC;
  localparam int unsigned XW = AW + 1;
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAttack  = 3'd1;
  localparam logic [2:0] StDecay   = 3'd2;
  localparam logic [2:0] StSustain = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  logic [CW-1:0]  ch_q, ch_d;
  logic [AW-1:0]  acc_q [NCH];
  logic [2:0]     st_q  [NCH];
  logic [NCH-1:0] gprev_q;

  logic [AW-1:0] acc_cur, acc_d;
  logic [2:0]    st_cur, st_d;
  logic          gate_cur, rise;
  logic [OW-1:0] pk_eff;
  logic [XW-1:0] acc_x, pk_x, sus_x, s_x, d_floor_x, r_floor_x;

  assign ch_d = (ch_q == LastCh) ? '0 : ch_q + CW'(1);

  // One extra bit on every compare so an add near full scale cannot wrap below the peak.
  always_comb begin
    acc_cur   = acc_q[ch_q];
    st_cur    = st_q[ch_q];
    gate_cur  = gate[ch_q];
    rise      = gate_cur & ~gprev_q[ch_q];
    pk_eff    = (pk_val > sus_lev) ? pk_val : sus_lev;
    acc_x     = {1'b0, acc_cur};
    pk_x      = XW'(pk_eff) << FRAC;
    sus_x     = XW'(sus_lev) << FRAC;
    s_x       = acc_x + XW'(a_rate);
    // acc - rate > floor  <=>  acc > floor + rate, which never goes negative.
    d_floor_x = sus_x + XW'(d_rate);
    r_floor_x = XW'(r_rate);
  end

  always_comb begin
    acc_d = acc_cur;
    st_d  = st_cur;
    if (rise) begin
      st_d = StAttack;
`ifdef POLY_ADSR_HARD_RETRIG_EN
      acc_d = '0;
`endif
    end else begin
      case (st_cur)
        StIdle: acc_d = '0;
        StAttack: begin
          if (!gate_cur) begin
            st_d = StRelease;
          end else if (s_x < pk_x) begin
            acc_d = s_x[AW-1:0];
          end else begin
            acc_d = pk_x[AW-1:0];
            st_d  = StDecay;
          end
        end
        StDecay: begin
          if (!gate_cur) begin
            st_d = StRelease;
          end else if (acc_x > d_floor_x) begin
            acc_d = acc_cur - AW'(d_rate);
          end else begin
            acc_d = sus_x[AW-1:0];
            st_d  = StSustain;
          end
        end
        StSustain: begin
          if (!gate_cur) st_d = StRelease;
        end
        StRelease: begin
          if (acc_x > r_floor_x) begin
            acc_d = acc_cur - AW'(r_rate);
          end else begin
            acc_d = '0;
            st_d  = StIdle;
          end
        end
        default: begin
          acc_d = '0;
          st_d  = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch_q    <= '0;
      gprev_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        st_q[i]  <= StIdle;
      end
      env.env_out    <= '0;
      env.env_ch     <= '0;
      env.env_valid  <= 1'b0;
      env.env_active <= '0;
    end else begin
      ch_q                 <= ch_d;
      acc_q[ch_q]          <= acc_d;
      st_q[ch_q]           <= st_d;
      gprev_q[ch_q]        <= gate_cur;
      env.env_out          <= acc_d[AW-1:FRAC];
      env.env_ch           <= ch_q;
      env.env_valid        <= 1'b1;
      env.env_active[ch_q] <= (st_d != StIdle);
    end
  end
endmodule

// File: tb/tb_poly_adsr.sv
// Self-checking bench for poly_adsr: per-scenario tasks with a queue of expected outputs.
// FRAC=16 so that a rate of 2^16 is exactly one output step per service.
module tb_poly_adsr;
  localparam int unsigned NCH  = 4;
  localparam int unsigned OW   = 18;
  localparam int unsigned FRAC = 16;
  localparam int unsigned CW   = 2;
  localparam logic [OW-1:0] Unit = 18'h10000;
  localparam logic [OW-1:0] RMax = 18'h3FFFF;

  logic           clock   = 1'b0;
  logic           reset_n = 1'b1;
  logic [NCH-1:0] gate    = '0;
  logic [OW-1:0]  a_rate  = '0;
  logic [OW-1:0]  d_rate  = '0;
  logic [OW-1:0]  sus_lev = '0;
  logic [OW-1:0]  r_rate  = '0;
  logic [OW-1:0]  pk_val  = '0;

  int unsigned    n_cmp = 0;
  int unsigned    n_bad = 0;
  int unsigned    exp_lvl[$];
  logic [NCH-1:0] exp_act[$];
  int unsigned    exp_ch[$];

  poly_adsr_if #(.NCH(NCH), .OW(OW), .CW(CW)) env_if ();

  poly_adsr #(.NCH(NCH), .OW(OW), .FRAC(FRAC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .gate    (gate),
    .a_rate  (a_rate),
    .d_rate  (d_rate),
    .sus_lev (sus_lev),
    .r_rate  (r_rate),
    .pk_val  (pk_val),
    .env     (env_if)
  );

  always #5 clock = ~clock;

  task automatic set_ctl(input logic [OW-1:0] a, input logic [OW-1:0] d, input logic [OW-1:0] s,
                         input logic [OW-1:0] r, input logic [OW-1:0] p);
    a_rate = a; d_rate = d; sus_lev = s; r_rate = r; pk_val = p;
  endtask

  // Wait (bounded) for the next output of voice ch; sampled on the falling edge.
  task automatic wait_ch(input int unsigned ch, output int unsigned lvl,
                         output logic [NCH-1:0] act, output bit ok);
    ok  = 1'b0;
    lvl = 0;
    act = '0;
    for (int i = 0; i < 4 * NCH; i++) begin
      @(negedge clock);
      if (env_if.env_valid === 1'b1 && env_if.env_ch == CW'(ch)) begin
        lvl = env_if.env_out;
        act = env_if.env_active;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (env_if.env_out !== '0 || env_if.env_ch !== '0 || env_if.env_valid !== 1'b0 ||
        env_if.env_active !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got out=%0d ch=%0d valid=%b act=%b, expected 0 0 0 0000",
               env_if.env_out, env_if.env_ch, env_if.env_valid, env_if.env_active);
    end
    repeat (2) @(negedge clock);
    n_cmp++;
    if (env_if.env_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold_valid: got %b, expected 0", env_if.env_valid);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (env_if.env_valid !== 1'b1 || env_if.env_ch !== '0 || env_if.env_out !== '0) begin
      n_bad++;
      $display("FAIL reset_first_out: got valid=%b ch=%0d out=%0d, expected 1 0 0",
               env_if.env_valid, env_if.env_ch, env_if.env_out);
    end
  endtask

  task automatic test_full_envelope;
    int unsigned e, lvl;
    logic [NCH-1:0] ea, act;
    bit ok;
    @(negedge clock);
    set_ctl(Unit, Unit, 18'd4, Unit, 18'd10);
    gate[0] = 1'b1;
    for (int v = 0; v <= 10; v++) begin exp_lvl.push_back(v); exp_act.push_back(4'b0001); end
    for (int v = 9; v >= 4; v--) begin exp_lvl.push_back(v); exp_act.push_back(4'b0001); end
    repeat (2) begin exp_lvl.push_back(4); exp_act.push_back(4'b0001); end
    for (int v = 4; v >= 1; v--) begin exp_lvl.push_back(v); exp_act.push_back(4'b0001); end
    exp_lvl.push_back(0); exp_act.push_back(4'b0000);
    for (int k = 0; exp_lvl.size() > 0; k++) begin
      e  = exp_lvl.pop_front();
      ea = exp_act.pop_front();
      wait_ch(0, lvl, act, ok);
      n_cmp++;
      if (!ok || lvl !== e || act !== ea) begin
        n_bad++;
        $display("FAIL full_env[%0d]: got ok=%0d lvl=%0d act=%b, expected lvl=%0d act=%b",
                 k, ok, lvl, act, e, ea);
      end
      if (k == 16) sus_lev = 18'd2;  // sustain must hold its captured level
      if (k == 18) gate[0] = 1'b0;
    end
  endtask

  task automatic test_peak_clamp;
    int unsigned e, lvl;
    logic [NCH-1:0] ea, act;
    bit ok;
    @(negedge clock);
    set_ctl(Unit, Unit, 18'd6, RMax, 18'd2);
    gate[1] = 1'b1;
    for (int v = 0; v <= 6; v++) begin exp_lvl.push_back(v); exp_act.push_back(4'b0010); end
    repeat (4) begin exp_lvl.push_back(6); exp_act.push_back(4'b0010); end
    exp_lvl.push_back(2); exp_act.push_back(4'b0010);
    exp_lvl.push_back(0); exp_act.push_back(4'b0000);
    for (int k = 0; exp_lvl.size() > 0; k++) begin
      e  = exp_lvl.pop_front();
      ea = exp_act.pop_front();
      wait_ch(1, lvl, act, ok);
      n_cmp++;
      if (!ok || lvl !== e || act !== ea) begin
        n_bad++;
        $display("FAIL peak_clamp[%0d]: got ok=%0d lvl=%0d act=%b, expected lvl=%0d act=%b",
                 k, ok, lvl, act, e, ea);
      end
      if (k == 9) gate[1] = 1'b0;
    end
  endtask

  task automatic test_retrigger;
    int unsigned e, lvl;
    logic [NCH-1:0] act;
    bit ok;
    @(negedge clock);
    set_ctl(Unit, Unit, 18'd4, Unit, 18'd10);
    gate[2] = 1'b1;
    for (int v = 0; v <= 10; v++) exp_lvl.push_back(v);
    for (int v = 9; v >= 5; v--) exp_lvl.push_back(v);
    exp_lvl.push_back(5);
`ifdef POLY_ADSR_HARD_RETRIG_EN
    for (int v = 0; v <= 2; v++) exp_lvl.push_back(v);
`else
    for (int v = 5; v <= 7; v++) exp_lvl.push_back(v);
`endif
    // Gate drops in decay at 7, so release reads 7, 6, 5 before the re-raise.
    for (int k = 0; exp_lvl.size() > 0; k++) begin
      e = (k == 14) ? 7 : (k == 15) ? 6 : exp_lvl[0];
      if (k != 14 && k != 15) void'(exp_lvl.pop_front());
      wait_ch(2, lvl, act, ok);
      n_cmp++;
      if (!ok || lvl !== e || act !== 4'b0100) begin
        n_bad++;
        $display("FAIL retrigger[%0d]: got ok=%0d lvl=%0d act=%b, expected lvl=%0d act=0100",
                 k, ok, lvl, act, e);
      end
      if (k == 13) gate[2] = 1'b0;
      if (k == 16) gate[2] = 1'b1;
      if (k == 13) begin void'(exp_lvl.pop_front()); void'(exp_lvl.pop_front()); end
    end
  endtask

  task automatic test_reset_midop;
    int unsigned lvl;
    logic [NCH-1:0] act;
    bit ok;
    @(negedge clock);
    set_ctl(Unit, Unit, 18'd4, Unit, 18'd10);
    gate = 4'b1111;
    repeat (14 * NCH) @(negedge clock);
    n_cmp++;
    if (env_if.env_active !== 4'b1111) begin
      n_bad++;
      $display("FAIL midop_active: got %b, expected 1111", env_if.env_active);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (env_if.env_out !== '0 || env_if.env_ch !== '0 || env_if.env_valid !== 1'b0 ||
        env_if.env_active !== '0) begin
      n_bad++;
      $display("FAIL midop_reset: got out=%0d ch=%0d valid=%b act=%b, expected 0 0 0 0000",
               env_if.env_out, env_if.env_ch, env_if.env_valid, env_if.env_active);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_ch.push_back(0); exp_lvl.push_back(0); exp_act.push_back(4'b0001);
    @(negedge clock);
    n_cmp++;
    if (env_if.env_valid !== 1'b1 || env_if.env_ch !== CW'(exp_ch.pop_front()) ||
        env_if.env_out !== OW'(exp_lvl.pop_front()) ||
        env_if.env_active !== exp_act.pop_front()) begin
      n_bad++;
      $display("FAIL midop_first: got valid=%b ch=%0d out=%0d act=%b, expected 1 0 0 0001",
               env_if.env_valid, env_if.env_ch, env_if.env_out, env_if.env_active);
    end
    wait_ch(0, lvl, act, ok);
    n_cmp++;
    if (!ok || lvl !== 1) begin
      n_bad++;
      $display("FAIL midop_rerise: got ok=%0d lvl=%0d, expected lvl=1", ok, lvl);
    end
  endtask

  task automatic test_channels;
    int unsigned ec, el;
    logic [NCH-1:0] ea;
    @(negedge clock);
    reset_n = 1'b0;
    gate    = 4'b1010;
    set_ctl(Unit, Unit, 18'd4, Unit, 18'd10);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_ch.push_back(c);
      exp_lvl.push_back(0);
      exp_act.push_back((c == 0) ? 4'b0000 : (c == 3) ? 4'b1010 : 4'b0010);
    end
    for (int c = 0; c < 4; c++) begin
      exp_ch.push_back(c);
      exp_lvl.push_back(c % 2);
      exp_act.push_back(4'b1010);
    end
    for (int k = 0; exp_ch.size() > 0; k++) begin
      ec = exp_ch.pop_front();
      el = exp_lvl.pop_front();
      ea = exp_act.pop_front();
      @(negedge clock);
      n_cmp++;
      if (env_if.env_valid !== 1'b1 || env_if.env_ch !== CW'(ec) ||
          env_if.env_out !== OW'(el) || env_if.env_active !== ea) begin
        n_bad++;
        $display("FAIL channels[%0d]: got valid=%b ch=%0d lvl=%0d act=%b, expected 1 %0d %0d %b",
                 k, env_if.env_valid, env_if.env_ch, env_if.env_out, env_if.env_active,
                 ec, el, ea);
      end
    end
  endtask

  task automatic test_overflow;
    int unsigned e, lvl;
    logic [NCH-1:0] act;
    bit ok;
    @(negedge clock);
    reset_n = 1'b0;
    gate    = '0;
    @(negedge clock);
    reset_n = 1'b1;
    set_ctl(Unit, Unit, 18'd4, 18'd0, 18'd10);
    gate[0] = 1'b1;
    for (int v = 0; v <= 10; v++) exp_lvl.push_back(v);
    exp_lvl.push_back(9);
    repeat (6) exp_lvl.push_back(int'(RMax));
    for (int k = 0; exp_lvl.size() > 0; k++) begin
      e = exp_lvl.pop_front();
      wait_ch(0, lvl, act, ok);
      n_cmp++;
      if (!ok || lvl !== e || act !== 4'b0001) begin
        n_bad++;
        $display("FAIL overflow[%0d]: got ok=%0d lvl=%0d act=%b, expected lvl=%0d act=0001",
                 k, ok, lvl, act, e);
      end
      if (k == 11) sus_lev = RMax;  // decay clamps upward to full scale
      if (k == 12) gate[0] = 1'b0;
      if (k == 14) begin
        pk_val  = RMax;
        a_rate  = RMax;
        gate[0] = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_envelope();
    test_peak_clamp();
    test_retrigger();
    test_reset_midop();
    test_channels();
`ifndef POLY_ADSR_HARD_RETRIG_EN
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
